// File: rtl/ts_write_arbiter_pkg.sv
// Shared constants, FSM encoding and width helper for the TS write arbiter.
package ts_write_arbiter_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } ts_state_e;

  // Index width that stays legal for a single-source build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ts_write_arbiter_if.sv
// Source byte streams, FIFO write port and status of the TS write arbiter.
interface ts_write_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_sop;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_ready;
  logic                          fifo_wfull;
  logic                          fifo_wen;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [NUM_SRC-1:0]            grant;
  logic [15:0]                   pkt_cnt;
  logic [15:0]                   sync_err_cnt;

  modport master (
    output src_valid, src_sop, src_data, fifo_wfull,
    input  src_ready, fifo_wen, fifo_wdata, grant, pkt_cnt, sync_err_cnt
  );

  modport slave (
    input  src_valid, src_sop, src_data, fifo_wfull,
    output src_ready, fifo_wen, fifo_wdata, grant, pkt_cnt, sync_err_cnt
  );

endinterface

// File: rtl/ts_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request found after last_grant, wrapping.
module rr_arbiter
  import ts_write_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W:0] cand_s;
  logic           found_s;

  // Walk last_grant+1 .. last_grant+NUM_SRC modulo NUM_SRC, keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_s = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(NUM_SRC)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_SRC);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IDX_W-1:0]]) begin
        gnt[cand_s[IDX_W-1:0]] = 1'b1;
        gnt_idx                = cand_s[IDX_W-1:0];
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ts_write_arbiter.sv
// Packet-granular arbiter merging NUM_SRC TS byte streams into one async-FIFO write port.
module ts_write_arbiter
  import ts_write_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = TS_PKT_LEN
) (
  input  logic              wclk,
  input  logic              wrst_n,
  ts_write_arbiter_if.slave bus
);

  localparam int         IDX_W    = idx_width(NUM_SRC);
  localparam logic [8:0] LAST_CNT = 9'(PKT_LEN - 1);

  ts_state_e             state_r, state_nxt_s;
  logic [NUM_SRC-1:0]    grant_r;
  logic [IDX_W-1:0]      grant_idx_r;
  logic [IDX_W-1:0]      last_grant_r;
  logic [8:0]            cnt_r;
  logic [15:0]           pkt_cnt_r;
  logic [15:0]           sync_err_cnt_r;

  logic [DATA_WIDTH-1:0] data_arr_s [NUM_SRC];
  logic [NUM_SRC-1:0]    cand_s;
  logic [NUM_SRC-1:0]    win_oh_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_sync_s;
  logic                  last_byte_s;
  logic [NUM_SRC-1:0]    ready_s;
  logic                  accept_s;
  logic                  wen_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slice
    assign data_arr_s[gi] = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cand_s      = bus.src_valid & bus.src_sop;
  // The SOP byte is held (ready=0) during arbitration, so it can be sync-checked now.
  assign win_sync_s  = (data_arr_s[win_idx_s] == DATA_WIDTH'(TS_SYNC_BYTE));
  assign last_byte_s = (cnt_r == LAST_CNT);

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (cand_s),
    .last_grant (last_grant_r),
    .gnt        (win_oh_s),
    .gnt_idx    (win_idx_s)
  );

  // Next state and combinational handshake towards sources and FIFO.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = '0;
    accept_s    = 1'b0;
    wen_s       = 1'b0;
    wdata_s     = '0;
    case (state_r)
      ST_IDLE: begin
        ready_s = bus.src_valid & ~bus.src_sop;
        if (|cand_s) begin
          state_nxt_s = win_sync_s ? ST_XFER : ST_DROP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        ready_s[grant_idx_r] = ~bus.fifo_wfull;
        accept_s             = bus.src_valid[grant_idx_r] & ~bus.fifo_wfull;
        wen_s                = accept_s;
        wdata_s              = data_arr_s[grant_idx_r];
        if (accept_s && last_byte_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_DROP: begin
        ready_s[grant_idx_r] = 1'b1;
        accept_s             = bus.src_valid[grant_idx_r];
        if (accept_s && last_byte_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant ownership, byte position and packet/error counters.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      grant_r        <= '0;
      grant_idx_r    <= '0;
      last_grant_r   <= IDX_W'(NUM_SRC - 1);
      cnt_r          <= 9'd0;
      pkt_cnt_r      <= 16'd0;
      sync_err_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|cand_s) begin
            grant_r     <= win_oh_s;
            grant_idx_r <= win_idx_s;
            cnt_r       <= 9'd0;
            if (!win_sync_s) begin
              sync_err_cnt_r <= sync_err_cnt_r + 16'd1;
            end
          end
        end
        ST_XFER, ST_DROP: begin
          if (accept_s) begin
            if (last_byte_s) begin
              grant_r      <= '0;
              last_grant_r <= grant_idx_r;
              cnt_r        <= 9'd0;
              if (state_r == ST_XFER) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
              end
            end else begin
              cnt_r <= cnt_r + 9'd1;
            end
          end
        end
        default: begin
          grant_r <= '0;
        end
      endcase
    end
  end

  // Handshake outputs are held inactive for the whole reset assertion.
  assign bus.src_ready    = wrst_n ? ready_s : '0;
  assign bus.fifo_wen     = wrst_n & wen_s;
  assign bus.fifo_wdata   = wdata_s;
  assign bus.grant        = grant_r;
  assign bus.pkt_cnt      = pkt_cnt_r;
  assign bus.sync_err_cnt = sync_err_cnt_r;

endmodule

// File: tb/tb_ts_write_arbiter.sv
// Directed bench for ts_write_arbiter: per-source packet model, write log and grant log.
module tb_ts_write_arbiter;
  import ts_write_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int PL = TS_PKT_LEN;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  ts_write_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  ts_write_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pos       [NS];
  int          pkts_left [NS];
  logic [7:0]  first_byte[NS];
  bit          junk      [NS];
  bit          wfull_q;
  bit          gap_en;
  int          glitch_pos;
  int          cyc = 0;
  logic [7:0]  wr_log[$];
  logic [7:0]  exp_log[$];
  logic [NS-1:0] grant_log[$];
  logic [NS-1:0] prev_grant;
  logic [NS-1:0] obs_ready, obs_grant;
  logic          obs_wen;

  function automatic logic [7:0] byte_of(input int s, input int k);
    if (k == 0) return first_byte[s];
    return 8'((k * 7 + s * 31 + 1) % 256);
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NS; i++) if (pkts_left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int log_mismatches();
    int bad = 0;
    for (int k = 0; k < wr_log.size() && k < exp_log.size(); k++)
      if (wr_log[k] !== exp_log[k]) bad++;
    return bad;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, advance the model on handshakes.
  task automatic tick();
    @(negedge wclk);
    bus.fifo_wfull = wfull_q;
    for (int i = 0; i < NS; i++) begin
      logic v;
      v = junk[i] || (pkts_left[i] > 0 && !(gap_en && (cyc % 3 == 2)));
      bus.src_valid[i]       = v;
      bus.src_sop[i]         = !junk[i] && v && (pos[i] == 0 || pos[i] == glitch_pos);
      bus.src_data[i*DW +: DW] = junk[i] ? 8'hAA : byte_of(i, pos[i]);
    end
    #1;
    obs_ready = bus.src_ready;
    obs_grant = bus.grant;
    obs_wen   = bus.fifo_wen;
    if (bus.fifo_wen) wr_log.push_back(bus.fifo_wdata);
    if (bus.grant != '0 && prev_grant == '0) grant_log.push_back(bus.grant);
    prev_grant = bus.grant;
    for (int i = 0; i < NS; i++) begin
      if (!junk[i] && bus.src_valid[i] && bus.src_ready[i] && bus.grant[i]) begin
        pos[i]++;
        if (pos[i] == PL) begin
          pos[i] = 0;
          pkts_left[i]--;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget, output bit done);
    int n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    done = !busy();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) begin
      pos[i] = 0; pkts_left[i] = 0; junk[i] = 1'b0; first_byte[i] = TS_SYNC_BYTE;
    end
    wfull_q = 1'b0; gap_en = 1'b0; glitch_pos = -1;
    @(negedge wclk);
    wrst_n = 1'b0;
    bus.src_valid = '0; bus.src_sop = '0; bus.src_data = '0; bus.fifo_wfull = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    wr_log.delete(); grant_log.delete(); exp_log.delete();
    prev_grant = '0;
  endtask

  task automatic test_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    bus.src_valid = 4'b1111; bus.src_sop = 4'b0000; bus.src_data = 32'h0; bus.fifo_wfull = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b expected 0000", bus.grant); end
    n_checks++; if (bus.src_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", bus.src_ready); end
    n_checks++; if (bus.fifo_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b expected 0", bus.fifo_wen); end
    n_checks++; if (bus.fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h expected 00", bus.fifo_wdata); end
    n_checks++; if (bus.pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d expected 0", bus.pkt_cnt); end
    n_checks++; if (bus.sync_err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d expected 0", bus.sync_err_cnt); end
    do_reset();
  endtask

  task automatic test_single_packet();
    bit done;
    do_reset();
    pkts_left[0] = 1;
    for (int k = 0; k < PL; k++) exp_log.push_back(byte_of(0, k));
    tick();
    n_checks++; if (obs_grant !== 4'b0000) begin n_fail++; $display("FAIL sp_arb_cycle_grant: got %b expected 0000", obs_grant); end
    n_checks++; if (obs_ready[0] !== 1'b0) begin n_fail++; $display("FAIL sp_sop_held: got %b expected 0", obs_ready[0]); end
    tick();
    n_checks++; if (obs_grant !== 4'b0001) begin n_fail++; $display("FAIL sp_grant: got %b expected 0001", obs_grant); end
    run_until_idle(600, done);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sp_timeout: got %0d expected 1", done); end
    tick();
    n_checks++; if (wr_log.size() !== PL) begin n_fail++; $display("FAIL sp_writes: got %0d expected %0d", wr_log.size(), PL); end
    n_checks++; if (log_mismatches() !== 0) begin n_fail++; $display("FAIL sp_data: got %0d bad bytes expected 0", log_mismatches()); end
    n_checks++; if (bus.pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL sp_pkt_cnt: got %0d expected 1", bus.pkt_cnt); end
    n_checks++; if (obs_grant !== 4'b0000) begin n_fail++; $display("FAIL sp_release: got %b expected 0000", obs_grant); end
  endtask

  task automatic test_round_robin();
    bit done;
    int bad = 0;
    do_reset();
    for (int i = 0; i < NS; i++) pkts_left[i] = 2;
    for (int n = 0; n < 8; n++) for (int k = 0; k < PL; k++) exp_log.push_back(byte_of(n % NS, k));
    run_until_idle(3000, done);
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rr_timeout: got %0d expected 1", done); end
    n_checks++; if (grant_log.size() !== 8) begin n_fail++; $display("FAIL rr_grants: got %0d expected 8", grant_log.size()); end
    for (int n = 0; n < grant_log.size() && n < 8; n++)
      if (grant_log[n] !== (4'b0001 << (n % NS))) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rr_order: got %0d out-of-order grants expected 0", bad); end
    n_checks++; if (wr_log.size() !== 8 * PL) begin n_fail++; $display("FAIL rr_writes: got %0d expected %0d", wr_log.size(), 8 * PL); end
    n_checks++; if (log_mismatches() !== 0) begin n_fail++; $display("FAIL rr_data: got %0d bad bytes expected 0", log_mismatches()); end
    n_checks++; if (bus.pkt_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_pkt_cnt: got %0d expected 8", bus.pkt_cnt); end
  endtask

  task automatic test_reset_midpacket();
    bit done;
    int n = 0;
    wr_log.delete(); exp_log.delete(); grant_log.delete();
    pkts_left[0] = 1;
    while (pos[0] != 50 && n < 400) begin tick(); n++; end
    n_checks++; if (pos[0] !== 50) begin n_fail++; $display("FAIL rm_reach50: got %0d expected 50", pos[0]); end
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rm_grant: got %b expected 0000", bus.grant); end
    n_checks++; if (bus.src_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready: got %b expected 0000", bus.src_ready); end
    n_checks++; if (bus.fifo_wen !== 1'b0) begin n_fail++; $display("FAIL rm_wen: got %b expected 0", bus.fifo_wen); end
    n_checks++; if (bus.pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_pkt_cnt: got %0d expected 0", bus.pkt_cnt); end
    @(negedge wclk);
    wrst_n = 1'b1;
    pos[0] = 0;
    wr_log.delete(); prev_grant = '0;
    for (int k = 0; k < PL; k++) exp_log.push_back(byte_of(0, k));
    tick();
    tick();
    n_checks++; if (obs_grant !== 4'b0001) begin n_fail++; $display("FAIL rm_regrant: got %b expected 0001", obs_grant); end
    run_until_idle(600, done);
    tick();
    n_checks++; if (wr_log.size() !== PL) begin n_fail++; $display("FAIL rm_writes: got %0d expected %0d", wr_log.size(), PL); end
    n_checks++; if (log_mismatches() !== 0) begin n_fail++; $display("FAIL rm_data: got %0d bad bytes expected 0", log_mismatches()); end
    n_checks++; if (bus.pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_pkt_cnt_after: got %0d expected 1", bus.pkt_cnt); end
  endtask

  task automatic test_stall();
    bit done;
    int n = 0;
    int bad = 0;
    do_reset();
    pkts_left[0] = 1;
    for (int k = 0; k < PL; k++) exp_log.push_back(byte_of(0, k));
    while (pos[0] != 100 && n < 400) begin tick(); n++; end
    wfull_q = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (obs_ready !== 4'b0000 || obs_wen !== 1'b0 || obs_grant !== 4'b0001) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL st_stall: got %0d bad cycles expected 0", bad); end
    n_checks++; if (pos[0] !== 100) begin n_fail++; $display("FAIL st_hold_pos: got %0d expected 100", pos[0]); end
    n_checks++; if (wr_log.size() !== 100) begin n_fail++; $display("FAIL st_writes_at_stall: got %0d expected 100", wr_log.size()); end
    wfull_q = 1'b0;
    run_until_idle(600, done);
    tick();
    n_checks++; if (wr_log.size() !== PL) begin n_fail++; $display("FAIL st_writes: got %0d expected %0d", wr_log.size(), PL); end
    n_checks++; if (log_mismatches() !== 0) begin n_fail++; $display("FAIL st_data: got %0d bad bytes expected 0", log_mismatches()); end
  endtask

  task automatic test_drop_and_single_candidate();
    bit done;
    do_reset();
    first_byte[2] = 8'h48;
    pkts_left[2] = 1;
    tick();
    tick();
    n_checks++; if (obs_grant !== 4'b0100) begin n_fail++; $display("FAIL dr_grant: got %b expected 0100", obs_grant); end
    run_until_idle(600, done);
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dr_consumed: got %0d expected 1", done); end
    n_checks++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL dr_writes: got %0d expected 0", wr_log.size()); end
    n_checks++; if (bus.sync_err_cnt !== 16'd1) begin n_fail++; $display("FAIL dr_err_cnt: got %0d expected 1", bus.sync_err_cnt); end
    n_checks++; if (bus.pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL dr_pkt_cnt: got %0d expected 0", bus.pkt_cnt); end
    // Source 2 is now lowest priority yet must still win when alone.
    first_byte[2] = TS_SYNC_BYTE;
    pkts_left[2] = 1;
    tick();
    tick();
    n_checks++; if (obs_grant !== 4'b0100) begin n_fail++; $display("FAIL sc_grant: got %b expected 0100", obs_grant); end
    run_until_idle(600, done);
    tick();
    n_checks++; if (bus.pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL sc_pkt_cnt: got %0d expected 1", bus.pkt_cnt); end
    n_checks++; if (wr_log.size() !== PL) begin n_fail++; $display("FAIL sc_writes: got %0d expected %0d", wr_log.size(), PL); end
  endtask

  task automatic test_gaps_midsop();
    bit done;
    do_reset();
    gap_en = 1'b1;
    glitch_pos = 60;
    pkts_left[3] = 1;
    for (int k = 0; k < PL; k++) exp_log.push_back(byte_of(3, k));
    run_until_idle(900, done);
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gp_timeout: got %0d expected 1", done); end
    n_checks++; if (wr_log.size() !== PL) begin n_fail++; $display("FAIL gp_writes: got %0d expected %0d", wr_log.size(), PL); end
    n_checks++; if (log_mismatches() !== 0) begin n_fail++; $display("FAIL gp_data: got %0d bad bytes expected 0", log_mismatches()); end
    n_checks++; if (bus.pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL gp_pkt_cnt: got %0d expected 1", bus.pkt_cnt); end
  endtask

  task automatic test_resync();
    int bad = 0;
    do_reset();
    junk[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (obs_ready !== 4'b0010 || obs_wen !== 1'b0 || obs_grant !== 4'b0000) bad++;
    end
    junk[1] = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rs_discard: got %0d bad cycles expected 0", bad); end
    n_checks++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL rs_writes: got %0d expected 0", wr_log.size()); end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      pos[i] = 0; pkts_left[i] = 0; junk[i] = 1'b0; first_byte[i] = TS_SYNC_BYTE;
    end
    wfull_q = 1'b0; gap_en = 1'b0; glitch_pos = -1; prev_grant = '0;
    bus.src_valid = '0; bus.src_sop = '0; bus.src_data = '0; bus.fifo_wfull = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_reset_midpacket();
    test_stall();
    test_drop_and_single_candidate();
    test_gaps_midsop();
    test_resync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
